spi_master_arb: RTL and testbench

- Single-channel SPI master shared by NREQ on-chip requesters; each transaction is one 8-bit full-duplex exchange.
- Round-robin arbitration picks a requester; the block drives ss (active-high), sclk (idle low, MOSI MSB first) and returns MISO data.
- Bus timing matches the team's 8-bit SPI slave: slave samples/shifts on sclk rising edge while ss=1 and clears its register when ss=0.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_rr_arb.sv | 47 ++++
 rtl/spi_master_arb.sv | 159 +++++++++++++++
 tb/tb_spi_master_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, default width and clog2 helper for the SPI master.
// Revision 1.0
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int DEFAULT_DW = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_rr_arb.sv
// spi_rr_arb: round-robin winner select with registered pointer advanced on grant.
// Revision 1.0
`default_nettype none

module spi_rr_arb
  import spi_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic            valid,
  output logic [IDW-1:0]  winner
);

  logic [IDW-1:0] ptr;

  // Scan downwards so the lowest offset from the pointer is written last and wins.
  always_comb begin
    int idx;
    idx    = 0;
    valid  = 1'b0;
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx[IDW-1:0]]) begin
        valid  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_arb.sv
// spi_master_arb: round-robin shared SPI master, one DW-bit full-duplex exchange per grant.
// Revision 1.0
`default_nettype none

module spi_master_arb
  import spi_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DW      = DEFAULT_DW,
  parameter int CLK_DIV = 2,
  localparam int IDW    = clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] tx_data,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [DW-1:0]      rx_data,
  output logic               done,
  output logic [IDW-1:0]     done_id,
  output logic               ss,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso
);

  localparam int BCW  = clog2(DW) + 1;
  localparam int DIVW = clog2(CLK_DIV) + 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [BCW-1:0]  BIT_LAST = BCW'(DW - 1);

  state_t          state;
  logic [DIVW-1:0] div;
  logic [BCW-1:0]  bitcnt;
  logic [DW-1:0]   tx_sh;
  logic [DW-1:0]   rx_sh;
  logic [DW-1:0]   rx_next;
  logic [IDW-1:0]  owner;

  logic            arb_valid;
  logic [IDW-1:0]  arb_winner;
  logic            arb_take;
  logic [DW-1:0]   tx_sel;
  logic [NREQ-1:0] gnt_vec;
  logic            div_wrap;
  logic [DIVW-1:0] div_step;

  assign arb_take = (state == IDLE) && arb_valid;
  assign div_wrap = (div == DIV_LAST);
  assign div_step = div_wrap ? '0 : div + DIVW'(1);

  spi_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (arb_take),
    .valid   (arb_valid),
    .winner  (arb_winner)
  );

  always_comb begin
    tx_sel  = '0;
    gnt_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_winner == IDW'(i)) begin
        tx_sel     = tx_data[i*DW +: DW];
        gnt_vec[i] = 1'b1;
      end
    end
  end

  // miso is captured in the first clk cycle of each sclk high phase.
  always_comb begin
    rx_next = rx_sh;
    if (state == SHIFT && sclk && div == '0) rx_next = {rx_sh[DW-2:0], miso};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      done_id <= '0;
      ss      <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      div     <= '0;
      bitcnt  <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      owner   <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt    <= gnt_vec;
            tx_sh  <= tx_sel;
            mosi   <= tx_sel[DW-1];
            ss     <= 1'b1;
            busy   <= 1'b1;
            owner  <= arb_winner;
            div    <= '0;
            bitcnt <= '0;
            rx_sh  <= '0;
            state  <= SETUP;
          end
        end
        SETUP: begin
          div <= div_step;
          if (div_wrap) begin
            sclk  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          div   <= div_step;
          rx_sh <= rx_next;
          if (div_wrap) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bitcnt == BIT_LAST) begin
              sclk    <= 1'b0;
              ss      <= 1'b0;
              mosi    <= 1'b0;
              done    <= 1'b1;
              rx_data <= rx_next;
              done_id <= owner;
              state   <= GAP;
            end else begin
              sclk   <= 1'b0;
              bitcnt <= bitcnt + BCW'(1);
              tx_sh  <= {tx_sh[DW-2:0], 1'b0};
              mosi   <= tx_sh[DW-2];
            end
          end
        end
        GAP: begin
          div <= div_step;
          if (div_wrap) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: directed bench for spi_master_arb (NREQ=2/3, CLK_DIV=2/1).
// Revision 1.0
`default_nettype none

module tb_spi_master_arb;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: NREQ=2, CLK_DIV=2
  logic [1:0]  a_req, a_gnt;
  logic [15:0] a_tx;
  logic [7:0]  a_rx;
  logic        a_busy, a_done, a_id, a_ss, a_sclk, a_mosi, a_miso, a_loop;

  // DUT B: NREQ=3, CLK_DIV=2, loopback
  logic [2:0]  b_req, b_gnt;
  logic [23:0] b_tx;
  logic [7:0]  b_rx;
  logic [1:0]  b_id;
  logic        b_busy, b_done, b_ss, b_sclk, b_mosi;

  // DUT C: NREQ=2, CLK_DIV=1, loopback
  logic [1:0]  c_req, c_gnt;
  logic [15:0] c_tx;
  logic [7:0]  c_rx;
  logic        c_busy, c_done, c_id, c_ss, c_sclk, c_mosi;

  // Behavioural 8-bit SPI slave on DUT A's bus
  logic [7:0] s_latch, s_sh, s_out;
  logic [3:0] s_cnt;
  logic       s_rdy, s_sclk_d;

  always @(posedge clk) begin
    s_sclk_d <= a_sclk;
    if (!a_ss) begin
      s_sh  <= s_latch;
      s_cnt <= 4'd0;
      s_rdy <= 1'b0;
    end else if (a_sclk && !s_sclk_d) begin
      s_sh  <= {s_sh[6:0], a_mosi};
      s_cnt <= s_cnt + 4'd1;
      if (s_cnt == 4'd7) begin
        s_rdy <= 1'b1;
        s_out <= {s_sh[6:0], a_mosi};
      end
    end
  end

  assign a_miso = a_loop ? a_mosi : s_sh[7];

  spi_master_arb #(.NREQ(2), .DW(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .tx_data(a_tx), .gnt(a_gnt), .busy(a_busy),
    .rx_data(a_rx), .done(a_done), .done_id(a_id), .ss(a_ss), .sclk(a_sclk),
    .mosi(a_mosi), .miso(a_miso));

  spi_master_arb #(.NREQ(3), .DW(8), .CLK_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .tx_data(b_tx), .gnt(b_gnt), .busy(b_busy),
    .rx_data(b_rx), .done(b_done), .done_id(b_id), .ss(b_ss), .sclk(b_sclk),
    .mosi(b_mosi), .miso(b_mosi));

  spi_master_arb #(.NREQ(2), .DW(8), .CLK_DIV(1)) dut_c (
    .clk(clk), .rst(rst), .req(c_req), .tx_data(c_tx), .gnt(c_gnt), .busy(c_busy),
    .rx_data(c_rx), .done(c_done), .done_id(c_id), .ss(c_ss), .sclk(c_sclk),
    .mosi(c_mosi), .miso(c_mosi));

  // Waits for a grant on DUT A and checks the full CLK_DIV=2 transfer; g = grant cycle.
  task automatic a_xfer(input logic [1:0] exp_gnt, input logic [7:0] exp_mosi,
                        input logic [7:0] exp_rx, input logic exp_id, input logic drop,
                        output int g);
    int  t;
    logic bad_ss, bad_sclk, early_done, exp_sclk;
    t = 0;
    g = -1;
    do begin
      @(negedge clk);
      t++;
    end while (a_gnt == 2'b00 && t < 60);
    checks++;
    if (a_gnt == 2'b00) begin
      errors++;
      $display("FAIL grant_timeout: no gnt within %0d cycles, expected %b", t, exp_gnt);
      return;
    end
    g = cyc;
    if (a_gnt !== exp_gnt) begin
      errors++;
      $display("FAIL gnt_value: got %b expected %b", a_gnt, exp_gnt);
    end
    checks++;
    if (a_ss !== 1'b1 || a_busy !== 1'b1 || a_sclk !== 1'b0) begin
      errors++;
      $display("FAIL grant_bus: ss=%b busy=%b sclk=%b expected 1 1 0", a_ss, a_busy, a_sclk);
    end
    if (drop) a_req = 2'b00;
    bad_ss = 1'b0; bad_sclk = 1'b0; early_done = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c < 32) begin
        exp_sclk = (c >= 2) && (((c - 2) % 4) < 2);
        if (a_ss !== 1'b1) bad_ss = 1'b1;
        if (a_sclk !== exp_sclk) bad_sclk = 1'b1;
        if (a_done !== 1'b0) early_done = 1'b1;
        if ((c % 4) == 2) begin
          checks++;
          if (a_mosi !== exp_mosi[7 - (c - 2) / 4]) begin
            errors++;
            $display("FAIL mosi_bit%0d: got %b expected %b", (c - 2) / 4, a_mosi,
                     exp_mosi[7 - (c - 2) / 4]);
          end
        end
      end else begin
        checks++;
        if (a_done !== 1'b1 || a_ss !== 1'b0 || a_sclk !== 1'b0) begin
          errors++;
          $display("FAIL done_cycle: done=%b ss=%b sclk=%b expected 1 0 0", a_done, a_ss, a_sclk);
        end
        checks++;
        if (a_rx !== exp_rx || a_id !== exp_id) begin
          errors++;
          $display("FAIL rx_result: rx=%h id=%0d expected rx=%h id=%0d", a_rx, a_id, exp_rx, exp_id);
        end
      end
    end
    checks++;
    if (bad_ss || bad_sclk || early_done) begin
      errors++;
      $display("FAIL bus_waveform: ss_err=%b sclk_err=%b early_done=%b expected 0 0 0",
               bad_ss, bad_sclk, early_done);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (a_gnt !== 2'b00 || a_busy !== 1'b0 || a_done !== 1'b0 || a_rx !== 8'h00 ||
        a_id !== 1'b0 || a_ss !== 1'b0 || a_sclk !== 1'b0 || a_mosi !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: gnt=%b busy=%b done=%b rx=%h id=%b ss=%b sclk=%b mosi=%b expected all 0",
               a_gnt, a_busy, a_done, a_rx, a_id, a_ss, a_sclk, a_mosi);
    end
    checks++;
    if (b_gnt !== 3'b000 || b_busy !== 1'b0 || b_id !== 2'd0 || c_ss !== 1'b0 || c_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_bc: b_gnt=%b b_busy=%b b_id=%0d c_ss=%b c_busy=%b expected all 0",
               b_gnt, b_busy, b_id, c_ss, c_busy);
    end
  endtask

  task automatic test_single;
    int n, g;
    repeat (4) @(negedge clk);
    a_loop = 1'b0; s_latch = 8'h3C;
    a_tx = 16'h00A5; a_req = 2'b01; n = cyc;
    a_xfer(2'b01, 8'hA5, 8'h3C, 1'b0, 1'b1, g);
    checks++;
    if (g !== n + 1) begin
      errors++;
      $display("FAIL single_latency: gnt at N+%0d expected N+1", g - n);
    end
  endtask

  task automatic test_back_to_back;
    int n, g1, g2;
    repeat (4) @(negedge clk);
    a_loop = 1'b1;
    a_tx = 16'h00FF; a_req = 2'b01; n = cyc;
    a_xfer(2'b01, 8'hFF, 8'hFF, 1'b0, 1'b0, g1);
    a_tx = 16'h0000;
    a_xfer(2'b01, 8'h00, 8'h00, 1'b0, 1'b1, g2);
    checks++;
    if (g1 !== n + 1 || g2 !== n + 36) begin
      errors++;
      $display("FAIL b2b_timing: gnts at N+%0d,N+%0d expected N+1,N+36", g1 - n, g2 - n);
    end
  endtask

  task automatic test_contention;
    int g, prev;
    logic [1:0] eg;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a_loop = 1'b1;
    a_tx = 16'hC312; a_req = 2'b11; prev = -1;
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      a_xfer(eg, (i % 2 == 0) ? 8'h12 : 8'hC3, (i % 2 == 0) ? 8'h12 : 8'hC3,
             (i % 2 == 0) ? 1'b0 : 1'b1, (i == 3), g);
      if (prev >= 0) begin
        checks++;
        if (g - prev !== 35) begin
          errors++;
          $display("FAIL contention_spacing%0d: %0d cycles expected 35", i, g - prev);
        end
      end
      prev = g;
    end
  endtask

  task automatic test_reset_mid;
    int t, g, n, g2;
    logic saw_done;
    repeat (4) @(negedge clk);
    a_loop = 1'b1;
    a_tx = 16'h775A; a_req = 2'b01; t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (a_gnt == 2'b00 && t < 60);
    g = cyc;
    a_req = 2'b00;
    while (cyc < g + 14 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (a_sclk !== 1'b1 || a_ss !== 1'b1 || a_mosi !== 1'b1 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: sclk=%b ss=%b mosi=%b busy=%b expected 1 1 1 1",
               a_sclk, a_ss, a_mosi, a_busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_ss !== 1'b0 || a_sclk !== 1'b0 || a_mosi !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: ss=%b sclk=%b mosi=%b busy=%b expected 0 0 0 0",
               a_ss, a_sclk, a_mosi, a_busy);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_done !== 1'b0) saw_done = 1'b1;
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (a_done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: done pulse seen=%b expected 0", saw_done);
    end
    a_req = 2'b10; n = cyc;
    a_xfer(2'b10, 8'h77, 8'h77, 1'b1, 1'b1, g2);
    checks++;
    if (g2 !== n + 1) begin
      errors++;
      $display("FAIL post_reset_latency: gnt at N+%0d expected N+1", g2 - n);
    end
  endtask

  task automatic test_slave;
    int g;
    repeat (4) @(negedge clk);
    a_loop = 1'b0; s_latch = 8'h96;
    a_tx = 16'h005A; a_req = 2'b01;
    a_xfer(2'b01, 8'h5A, 8'h96, 1'b0, 1'b1, g);
    checks++;
    if (s_rdy !== 1'b1 || s_out !== 8'h5A) begin
      errors++;
      $display("FAIL slave_rx: data_rdy=%b data_out=%h expected 1 5a", s_rdy, s_out);
    end
  endtask

  task automatic test_nreq3;
    int order [3] = '{0, 2, 0};
    int t;
    logic [2:0] eg;
    logic [7:0] er;
    repeat (4) @(negedge clk);
    b_tx = 24'hC0B0A0; b_req = 3'b101;
    for (int i = 0; i < 3; i++) begin
      eg = 3'(1 << order[i]);
      er = (order[i] == 0) ? 8'hA0 : 8'hC0;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (b_gnt == 3'b000 && t < 60);
      checks++;
      if (b_gnt !== eg) begin
        errors++;
        $display("FAIL nreq3_gnt%0d: got %b expected %b", i, b_gnt, eg);
      end
      if (i == 2) b_req = 3'b000;
      do begin
        @(negedge clk);
        t++;
      end while (b_done !== 1'b1 && t < 120);
      checks++;
      if (b_done !== 1'b1 || b_id !== 2'(order[i]) || b_rx !== er) begin
        errors++;
        $display("FAIL nreq3_done%0d: done=%b id=%0d rx=%h expected 1 %0d %h",
                 i, b_done, b_id, b_rx, order[i], er);
      end
    end
  endtask

  task automatic test_div1;
    int n;
    logic bad_sclk, early_done;
    repeat (4) @(negedge clk);
    c_tx = 16'h0081; c_req = 2'b01; n = cyc;
    @(negedge clk);
    checks++;
    if (c_gnt !== 2'b01 || c_ss !== 1'b1) begin
      errors++;
      $display("FAIL div1_gnt: gnt=%b ss=%b expected 01 1", c_gnt, c_ss);
    end
    c_req = 2'b00;
    bad_sclk = 1'b0; early_done = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c < 16) begin
        if (c_sclk !== ((c % 2) == 1)) bad_sclk = 1'b1;
        if (c_done !== 1'b0) early_done = 1'b1;
      end
    end
    checks++;
    if (bad_sclk || early_done) begin
      errors++;
      $display("FAIL div1_waveform: sclk_err=%b early_done=%b expected 0 0", bad_sclk, early_done);
    end
    checks++;
    if (c_done !== 1'b1 || cyc !== n + 17 || c_rx !== 8'h81 || c_sclk !== 1'b0) begin
      errors++;
      $display("FAIL div1_done: done=%b at N+%0d rx=%h sclk=%b expected 1 at N+17 81 0",
               c_done, cyc - n, c_rx, c_sclk);
    end
  endtask

  initial begin
    rst = 1'b0;
    a_req = '0; a_tx = '0; a_loop = 1'b1; s_latch = 8'h00;
    b_req = '0; b_tx = '0;
    c_req = '0; c_tx = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_single;
    test_back_to_back;
    test_contention;
    test_reset_mid;
    test_slave;
    test_nreq3;
    test_div1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
